// File: rtl/dm_obi_slave_adapter.sv
// OBI slave front-end for the debug module memory window: fixed-latency logint port,
// in-order responses through a fall-through FIFO. Optional address check: DM_OBI_ADDR_CHECK_EN.
module dm_obi_slave_adapter #(
   parameter int unsigned IdWidth       = 1,
   parameter int unsigned BusWidth      = 32,
   parameter int unsigned DmLatency     = 1,
   parameter int unsigned RespDepth     = 2,
   parameter int unsigned DmBaseAddress = 'h1000,
   parameter int unsigned DmAddrSpan    = 'h1000
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           obi_req_i,
   output logic                           obi_gnt_o,
   input  logic                           obi_we_i,
   input  logic [BusWidth-1:0]            obi_addr_i,
   input  logic [BusWidth/8-1:0]          obi_be_i,
   input  logic [BusWidth-1:0]            obi_wdata_i,
   input  logic [IdWidth-1:0]             obi_aid_i,
   output logic                           obi_rvalid_o,
   input  logic                           obi_rready_i,
   output logic [BusWidth-1:0]            obi_rdata_o,
   output logic [IdWidth-1:0]             obi_rid_o,
   output logic                           obi_err_o,
   output logic                           dm_req_o,
   output logic                           dm_we_o,
   output logic [BusWidth-1:0]            dm_addr_o,
   output logic [BusWidth/8-1:0]          dm_be_o,
   output logic [BusWidth-1:0]            dm_wdata_o,
   input  logic [BusWidth-1:0]            dm_rdata_i,
   output logic [$clog2(RespDepth+1)-1:0] outstanding_o
);

   localparam int unsigned CntW = $clog2(RespDepth + 1);
   localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
   localparam int unsigned Last = DmLatency - 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(RespDepth);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(RespDepth - 1);

   if (DmLatency < 1 || DmLatency > 4 || RespDepth < 1 || DmAddrSpan == 0 ||
       (longint'(DmBaseAddress) + longint'(DmAddrSpan)) > (longint'(1) << BusWidth))
   begin : g_bad_params
      $error("dm_obi_slave_adapter: illegal parameter combination");
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   logic [CntW-1:0] cnt;
   logic            gnt;
   logic            accept;
   logic            addr_err;
   logic            resp_fire;

   // Grant depends only on registered credit count, never on req or rready.
   assign gnt       = !rst_i && (cnt < DepthCnt);
   assign accept    = obi_req_i && gnt;
   assign obi_gnt_o = gnt;

`ifdef DM_OBI_ADDR_CHECK_EN
   localparam int unsigned AW = BusWidth + 1;
   localparam logic [BusWidth:0] AddrLo = AW'(DmBaseAddress);
   localparam logic [BusWidth:0] AddrHi = AddrLo + AW'(DmAddrSpan);
   assign addr_err = ({1'b0, obi_addr_i} < AddrLo) || ({1'b0, obi_addr_i} >= AddrHi);
`else
   assign addr_err = 1'b0;
`endif

   assign dm_req_o   = accept && !addr_err;
   assign dm_we_o    = obi_we_i;
   assign dm_addr_o  = obi_addr_i;
   assign dm_be_o    = obi_be_i;
   assign dm_wdata_o = obi_wdata_i;

   // ---- latency pipe: stage 0 captures the accept, last stage meets dm_rdata_i ----
   logic               vld_p [DmLatency];
   logic [IdWidth-1:0] id_p  [DmLatency];
   logic               we_p  [DmLatency];
   logic               err_p [DmLatency];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DmLatency; i++) vld_p[i] <= 1'b0;
      end else begin
         vld_p[0] <= accept;
         for (int i = 1; i < DmLatency; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      id_p[0]  <= obi_aid_i;
      we_p[0]  <= obi_we_i;
      err_p[0] <= addr_err;
      for (int i = 1; i < DmLatency; i++) begin
         id_p[i]  <= id_p[i-1];
         we_p[i]  <= we_p[i-1];
         err_p[i] <= err_p[i-1];
      end
   end

   logic                pout_vld;
   logic [BusWidth-1:0] pout_rdata;

   assign pout_vld   = vld_p[Last];
   assign pout_rdata = (we_p[Last] || err_p[Last]) ? '0 : dm_rdata_i;

   // ---- response FIFO: bypassed while empty so the earliest response costs no extra cycle ----
   logic [BusWidth-1:0] fifo_rdata [RespDepth];
   logic [IdWidth-1:0]  fifo_rid   [RespDepth];
   logic                fifo_err   [RespDepth];
   logic [PtrW-1:0]     wptr, rptr;
   logic [CntW-1:0]     fcnt;
   logic                fifo_empty, push, pop;

   assign fifo_empty = (fcnt == '0);
   assign push       = pout_vld && !(fifo_empty && obi_rready_i);
   assign pop        = !fifo_empty && obi_rready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
         fcnt <= '0;
      end else begin
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   fcnt <= fcnt + 1'b1;
            2'b01:   fcnt <= fcnt - 1'b1;
            default: fcnt <= fcnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_rdata[wptr] <= pout_rdata;
         fifo_rid[wptr]   <= id_p[Last];
         fifo_err[wptr]   <= err_p[Last];
      end
   end

   assign obi_rvalid_o = fifo_empty ? pout_vld    : 1'b1;
   assign obi_rdata_o  = fifo_empty ? pout_rdata  : fifo_rdata[rptr];
   assign obi_rid_o    = fifo_empty ? id_p[Last]  : fifo_rid[rptr];
   assign obi_err_o    = fifo_empty ? err_p[Last] : fifo_err[rptr];

   // Credits cover pipe plus FIFO, so the FIFO cannot overflow.
   assign resp_fire = obi_rvalid_o && obi_rready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else begin
         case ({accept, resp_fire})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign outstanding_o = cnt;

endmodule

// File: doc/dm_obi_slave_adapter.md
Name: dm_obi_slave_adapter

Overview:
- Parametrised OBI slave front-end for the debug module memory window.
- Converts OBI transactions (aid/rid, rvalid/rready, err) into the debug module's fixed-latency logint slave port.
- Supports multiple outstanding transactions, configurable downstream read latency, and response back-pressure via a response FIFO.
- Sits between the system interconnect and the debug module slave port.

Parameters:
- IdWidth, 1: width of aid/rid.
- BusWidth, 32: data/address width; be width is BusWidth/8.
- DmLatency, 1: cycles from granted request to valid dm_rdata_i. Legal range 1..4.
- RespDepth, 2: maximum outstanding transactions, counting the latency pipe plus the response FIFO. Must be >= 1.
- DmBaseAddress, 'h1000: base address of the debug window.
- DmAddrSpan, 'h1000: size of the debug window in bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- obi_req_i  in  1  OBI address-phase request
- obi_gnt_o  out  1  OBI grant
- obi_we_i  in  1  write enable
- obi_addr_i  in  BusWidth  address
- obi_be_i  in  BusWidth/8  byte enables
- obi_wdata_i  in  BusWidth  write data
- obi_aid_i  in  IdWidth  address-phase id
- obi_rvalid_o  out  1  response valid
- obi_rready_i  in  1  response ready
- obi_rdata_o  out  BusWidth  response data
- obi_rid_o  out  IdWidth  response id (mirrors aid)
- obi_err_o  out  1  response error
- dm_req_o  out  1  logint request to debug module
- dm_we_o  out  1  logint write enable
- dm_addr_o  out  BusWidth  logint address
- dm_be_o  out  BusWidth/8  logint byte enables
- dm_wdata_o  out  BusWidth  logint write data
- dm_rdata_i  in  BusWidth  logint read data, valid DmLatency cycles after dm_req_o
- outstanding_o  out  $clog2(RespDepth+1)  current outstanding count

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state (cycle after rst_i sampled high): pipe, FIFO and counter cleared; obi_rvalid_o=0, obi_err_o=0, outstanding_o=0.
- While rst_i is high: obi_gnt_o=0 and dm_req_o=0 (combinational gating); in-flight responses are discarded.
- Grant: obi_gnt_o = !rst_i && (outstanding_o < RespDepth). No combinational path from obi_rready_i or obi_req_i to obi_gnt_o.
- Accept: a transaction is accepted when obi_req_i && obi_gnt_o.
  - dm_req_o equals accept.
  - dm_we/addr/be/wdata pass through combinationally from the obi_* inputs.
- Latency pipe:
  - DmLatency stages, each holding {valid, id, we, err}; advances every cycle (no stall).
  - Stage DmLatency output captures dm_rdata_i.
  - Write responses return rdata=0.
- Response path:
  - Response FIFO of RespDepth entries holding {rdata, rid, err}.
  - Fall-through: when the FIFO is empty, the pipe output drives obi_rvalid_o/rdata/rid directly in the same cycle. If obi_rready_i=1 that cycle, nothing is stored; otherwise the entry is pushed.
  - When the FIFO is non-empty, the head drives the outputs and new pipe outputs are pushed behind it.
  - Responses are strictly in order.
- Earliest response: obi_rvalid_o rises DmLatency cycles after the accept cycle (DmLatency=1 gives the cycle after the grant).
- Outputs while obi_rvalid_o=0: obi_rdata_o, obi_rid_o and obi_err_o are don't-care.
- OBI stability: while obi_rvalid_o=1 and obi_rready_i=0, obi_rdata_o, obi_rid_o and obi_err_o hold stable.
- Counter:
  - +1 on accept, -1 on obi_rvalid_o && obi_rready_i; unchanged when both occur in the same cycle.
  - Saturates by construction at RespDepth, so the FIFO can never overflow.
- Full boundary: at outstanding_o==RespDepth with a pop in the same cycle, obi_gnt_o stays 0 that cycle and rises the next cycle.
- Empty boundary: with an empty FIFO and an empty pipe, obi_rvalid_o=0 regardless of obi_rready_i.

Optional Feature:
- Macro: DM_OBI_ADDR_CHECK_EN.
- Defined:
  - An accepted address outside [DmBaseAddress, DmBaseAddress+DmAddrSpan) is not forwarded; dm_req_o stays 0.
  - The transaction still occupies a pipe slot and a counter credit.
  - Its response returns obi_err_o=1, rdata=0, with ordering preserved.
- Undefined: every accepted request is forwarded; obi_err_o is tied to 0.

Test Plan:
- DmLatency=1, RespDepth=2, rready=1: read aid=1 at addr 'h1100, dm_rdata_i='hDEADBEEF one cycle later -> rvalid=1 the next cycle, rdata='hDEADBEEF, rid=1, err=0.
- Back-to-back reads aid=0,1,0,1 with rready=1 -> gnt held at 1 every cycle, rvalid on 4 consecutive cycles, rid sequence 0,1,0,1.
- rready=0, requests held -> exactly 2 grants then gnt=0 and outstanding_o=2; on raising rready, responses come out in order with data stable while stalled; gnt returns the cycle after the first pop.
- Counter full with a pop in the same cycle -> gnt=0 that cycle; outstanding_o goes 2->1 and gnt=1 the next cycle.
- rst_i asserted for one cycle with 2 transactions outstanding -> the next cycle shows rvalid=0, outstanding_o=0, gnt=1, and no stale response appears later.
- DM_OBI_ADDR_CHECK_EN defined: write to 'h0 -> dm_req_o=0, response rvalid with err=1, rdata=0; a following in-range read is unaffected.
